// File: rtl/ast_framing_fifo_pkg.sv
// rtl/ast_framing_fifo_pkg.sv - shared widths, types and FSM states for the framing FIFO
package ast_framing_fifo_pkg;

  localparam int DATA_IN_W  = 64;
  localparam int CHANNEL_W  = 10;
  localparam int EMPTY_IN_W = $clog2(DATA_IN_W / 8) ? $clog2(DATA_IN_W / 8) : 1;
  localparam int FIFO_DEPTH = 8;

  typedef logic [CHANNEL_W-1:0]  channel_t;
  typedef logic [EMPTY_IN_W-1:0] empty_in_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

endpackage

// File: rtl/ast_fifo_mem.sv
// rtl/ast_fifo_mem.sv - register-array storage with one write port and asynchronous read
module ast_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is not reset: an entry is only observable after it has been written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ast_framing_fifo.sv
// rtl/ast_framing_fifo.sv - packet-sanitising show-ahead FIFO ahead of the width converter
module ast_framing_fifo #(
  parameter int DATA_W    = ast_framing_fifo_pkg::DATA_IN_W,
  parameter int CHANNEL_W = ast_framing_fifo_pkg::CHANNEL_W,
  parameter int EMPTY_W   = $clog2(DATA_W / 8) ? $clog2(DATA_W / 8) : 1,
  parameter int DEPTH     = ast_framing_fifo_pkg::FIFO_DEPTH,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [DATA_W-1:0]    ast_data_i,
  input  logic                 ast_startofpacket_i,
  input  logic                 ast_endofpacket_i,
  input  logic                 ast_valid_i,
  input  logic [EMPTY_W-1:0]   ast_empty_i,
  input  logic [CHANNEL_W-1:0] ast_channel_i,
  output logic                 ast_ready_o,
  output logic [DATA_W-1:0]    ast_data_o,
  output logic                 ast_startofpacket_o,
  output logic                 ast_endofpacket_o,
  output logic                 ast_valid_o,
  output logic [EMPTY_W-1:0]   ast_empty_o,
  output logic [CHANNEL_W-1:0] ast_channel_o,
  input  logic                 ast_ready_i,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic                 sop_err_o
);

  import ast_framing_fifo_pkg::*;

  localparam int AW      = $clog2(DEPTH);
  localparam int PTR_W   = AW + 1;
  localparam int ENTRY_W = DATA_W + CHANNEL_W + EMPTY_W + 2;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, used;
  logic [CHANNEL_W-1:0] ch_q;
  logic [CNT_W-1:0]     drop_cnt;
  logic                 sop_err_q;

  logic                 accept, pop;
  logic                 wr_en, drop, latch_ch, sop_err_d;
  logic [CHANNEL_W-1:0] wr_channel;
  logic [EMPTY_W-1:0]   wr_empty;
  logic [ENTRY_W-1:0]   wr_entry, rd_entry;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign used        = wr_ptr - rd_ptr;
  assign ast_ready_o = !srst_i && (used < PTR_W'(DEPTH));
  assign accept      = ast_valid_i && ast_ready_o;
  assign ast_valid_o = (used != '0);
  assign pop         = ast_valid_o && ast_ready_i;

  // SOP beats carry their own channel; continuation beats inherit the packet's channel.
  assign wr_channel = ast_startofpacket_i ? ast_channel_i : ch_q;
  assign wr_empty   = ast_endofpacket_i ? ast_empty_i : '0;
  assign wr_entry   = {ast_data_i, wr_channel, wr_empty, ast_startofpacket_i, ast_endofpacket_i};

  ast_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk_i),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  // Outputs read zero whenever nothing is presented, including straight out of reset.
  assign {ast_data_o, ast_channel_o, ast_empty_o, ast_startofpacket_o, ast_endofpacket_o} =
    ast_valid_o ? rd_entry : '0;

  assign drop_cnt_o = drop_cnt;
  assign sop_err_o  = sop_err_q;

  // Framing decisions for each accepted beat: write, drop, re-latch channel, flag SOP error.
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    drop      = 1'b0;
    latch_ch  = 1'b0;
    sop_err_d = 1'b0;
    if (accept) begin
      if (ast_startofpacket_i) begin
        wr_en     = 1'b1;
        latch_ch  = 1'b1;
        sop_err_d = (state_q == ST_IN_PKT);
        state_d   = ast_endofpacket_i ? ST_IDLE : ST_IN_PKT;
      end else if (state_q == ST_IN_PKT) begin
        wr_en = 1'b1;
        if (ast_endofpacket_i) begin
          state_d = ST_IDLE;
        end
      end else begin
        drop = 1'b1;
      end
    end
  end

  // State, pointers, channel latch and status counters.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ch_q      <= '0;
      drop_cnt  <= '0;
      sop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sop_err_q <= sop_err_d;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (latch_ch) begin
        ch_q <= ast_channel_i;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ast_framing_fifo.sv
// tb/tb_ast_framing_fifo.sv - self-checking bench for ast_framing_fifo
module tb_ast_framing_fifo;

  import ast_framing_fifo_pkg::*;

  localparam int DEPTH   = FIFO_DEPTH;
  localparam int CNT_MAX = 65535;

  logic                 clk = 1'b0;
  logic                 srst;
  logic [DATA_IN_W-1:0] data_i;
  logic                 sop_i, eop_i, valid_i, ready_i;
  empty_in_t            empty_i;
  channel_t             ch_i;
  logic                 ready_o, sop_o, eop_o, valid_o, sop_err;
  logic [DATA_IN_W-1:0] data_o;
  empty_in_t            empty_o;
  channel_t             ch_o;
  logic [15:0]          drop_cnt;

  always #5 clk = ~clk;

  ast_framing_fifo dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .ast_data_i          (data_i),
    .ast_startofpacket_i (sop_i),
    .ast_endofpacket_i   (eop_i),
    .ast_valid_i         (valid_i),
    .ast_empty_i         (empty_i),
    .ast_channel_i       (ch_i),
    .ast_ready_o         (ready_o),
    .ast_data_o          (data_o),
    .ast_startofpacket_o (sop_o),
    .ast_endofpacket_o   (eop_o),
    .ast_valid_o         (valid_o),
    .ast_empty_o         (empty_o),
    .ast_channel_o       (ch_o),
    .ast_ready_i         (ready_i),
    .drop_cnt_o          (drop_cnt),
    .sop_err_o           (sop_err)
  );

  typedef struct {
    logic [DATA_IN_W-1:0] data;
    channel_t             ch;
    empty_in_t            empty;
    logic                 sop;
    logic                 eop;
  } beat_t;

  typedef struct {
    logic                 v, sop, eop;
    logic [DATA_IN_W-1:0] d;
    empty_in_t            e;
    channel_t             ch;
    logic                 rdy;
    logic                 x_v;
    logic [DATA_IN_W-1:0] x_d;
    logic                 x_sop, x_eop;
    empty_in_t            x_e;
    channel_t             x_ch;
    logic                 x_rdy;
  } vec_t;

  beat_t       q[$];
  bit          in_pkt;
  channel_t    m_ch;
  int unsigned m_drop;
  bit          m_err;
  bit          m_acc;
  int          pops;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[4];
  int          idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop,
                       input logic [63:0] d, input logic [2:0] e, input logic [9:0] ch);
    valid_i = v;
    sop_i   = sop;
    eop_i   = eop;
    data_i  = d;
    empty_i = e;
    ch_i    = ch;
  endtask

  // Reference: a packet queue plus an in-packet flag, advanced once per clock edge.
  task automatic model_update();
    bit    pop_now;
    beat_t b;
    m_acc = 1'b0;
    if (srst) begin
      q.delete();
      in_pkt = 1'b0;
      m_ch   = '0;
      m_drop = 0;
      m_err  = 1'b0;
      return;
    end
    m_acc   = valid_i && (q.size() < DEPTH);
    pop_now = (q.size() != 0) && ready_i;
    m_err   = 1'b0;
    if (pop_now) begin
      void'(q.pop_front());
      pops++;
    end
    if (m_acc) begin
      b.data  = data_i;
      b.sop   = sop_i;
      b.eop   = eop_i;
      b.empty = eop_i ? empty_i : '0;
      if (sop_i) begin
        m_err  = in_pkt;
        m_ch   = ch_i;
        b.ch   = ch_i;
        in_pkt = !eop_i;
        q.push_back(b);
      end else if (in_pkt) begin
        b.ch   = m_ch;
        in_pkt = !eop_i;
        q.push_back(b);
      end else if (m_drop != CNT_MAX) begin
        m_drop++;
      end
    end
  endtask

  task automatic model_check();
    chk("ready", 64'(ready_o), 64'(!srst && (q.size() < DEPTH)));
    chk("valid", 64'(valid_o), 64'(q.size() != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("sop_err", 64'(sop_err), 64'(m_err));
    if (q.size() != 0) begin
      chk("head_data", data_o, q[0].data);
      chk("head_channel", 64'(ch_o), 64'(q[0].ch));
      chk("head_empty", 64'(empty_o), 64'(q[0].empty));
      chk("head_sop", 64'(sop_o), 64'(q[0].sop));
      chk("head_eop", 64'(eop_o), 64'(q[0].eop));
    end
  endtask

  // One clock: inputs already driven, model advances at the edge, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tick();
  endtask

  initial begin
    srst    = 1'b1;
    ready_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    in_pkt  = 1'b0;
    m_ch    = '0;
    m_drop  = 0;
    m_err   = 1'b0;
    pops    = 0;
    @(negedge clk);

    // Reset state
    tick();
    tick();
    chk("rst_data", data_o, 64'd0);
    chk("rst_sop", 64'(sop_o), 64'd0);
    chk("rst_eop", 64'(eop_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd0);
    chk("rst_channel", 64'(ch_o), 64'd0);
    srst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(ready_o), 64'd1);

    // 3-beat packet on channel 5, downstream always ready
    tbl[0] = '{1, 1, 0, 64'd1, 3'd0, 10'd5, 1,  1, 64'd1, 1, 0, 3'd0, 10'd5, 1};
    tbl[1] = '{1, 0, 0, 64'd2, 3'd0, 10'd5, 1,  1, 64'd2, 0, 0, 3'd0, 10'd5, 1};
    tbl[2] = '{1, 0, 1, 64'd3, 3'd3, 10'd5, 1,  1, 64'd3, 0, 1, 3'd3, 10'd5, 1};
    tbl[3] = '{0, 0, 0, 64'd0, 3'd0, 10'd0, 1,  0, 64'd0, 0, 0, 3'd0, 10'd0, 1};
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].d, tbl[i].e, tbl[i].ch);
      ready_i = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(valid_o), 64'(tbl[i].x_v));
      chk($sformatf("vec%0d_ready", i), 64'(ready_o), 64'(tbl[i].x_rdy));
      if (tbl[i].x_v) begin
        chk($sformatf("vec%0d_data", i), data_o, tbl[i].x_d);
        chk($sformatf("vec%0d_sop", i), 64'(sop_o), 64'(tbl[i].x_sop));
        chk($sformatf("vec%0d_eop", i), 64'(eop_o), 64'(tbl[i].x_eop));
        chk($sformatf("vec%0d_empty", i), 64'(empty_o), 64'(tbl[i].x_e));
        chk($sformatf("vec%0d_channel", i), 64'(ch_o), 64'(tbl[i].x_ch));
      end
    end

    // 12-beat packet into a blocked downstream, then drain
    ready_i = 1'b0;
    idx     = 0;
    pops    = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1, idx == 0, idx == 11, 64'(100 + idx), 3'd1, 10'd4);
      tick();
      if (m_acc) idx++;
    end
    chk("accepts_while_blocked", 64'(idx), 64'd8);
    chk("ready_when_full", 64'(ready_o), 64'd0);
    ready_i = 1'b1;
    for (int c = 0; c < 40 && idx < 12; c++) begin
      drive(1, idx == 0, idx == 11, 64'(100 + idx), 3'd1, 10'd4);
      tick();
      if (m_acc) idx++;
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20 && q.size() != 0; c++) tick();
    chk("all_beats_sent", 64'(idx), 64'd12);
    chk("all_beats_drained", 64'(pops), 64'd12);

    // Stray beat while idle, then a proper packet
    do_reset();
    drive(1, 0, 0, 64'hAA, 3'd0, 10'd1);
    tick();
    chk("stray_not_output", 64'(valid_o), 64'd0);
    chk("stray_drop_cnt", 64'(drop_cnt), 64'd1);
    drive(1, 1, 0, 64'h30, 3'd0, 10'd6); tick();
    drive(1, 0, 1, 64'h31, 3'd2, 10'd6); tick();
    drive(0, 0, 0, 0, 0, 0); tick(); tick();

    // Channel locked to 2 despite a mid-packet channel change; empty zeroed off EOP
    drive(1, 1, 0, 64'd20, 3'd0, 10'd2); tick();
    drive(1, 0, 0, 64'd21, 3'd5, 10'd7); tick();
    chk("locked_channel", 64'(ch_o), 64'd2);
    chk("non_eop_empty", 64'(empty_o), 64'd0);
    drive(1, 0, 1, 64'd22, 3'd4, 10'd7); tick();
    chk("locked_channel_eop", 64'(ch_o), 64'd2);
    chk("eop_empty", 64'(empty_o), 64'd4);
    drive(0, 0, 0, 0, 0, 0); tick();

    // SOP on channel 3 while inside a packet
    drive(1, 1, 0, 64'd10, 3'd0, 10'd1); tick();
    drive(1, 0, 0, 64'd11, 3'd0, 10'd1); tick();
    chk("sop_err_idle", 64'(sop_err), 64'd0);
    drive(1, 1, 0, 64'd12, 3'd0, 10'd3); tick();
    chk("sop_err_pulse", 64'(sop_err), 64'd1);
    drive(1, 0, 0, 64'd13, 3'd0, 10'd9); tick();
    chk("sop_err_clear", 64'(sop_err), 64'd0);
    drive(1, 0, 1, 64'd14, 3'd2, 10'd9); tick();
    chk("channel_after_resop", 64'(ch_o), 64'd3);
    drive(0, 0, 0, 0, 0, 0); tick();

    // Reset with four beats of an open packet stored
    ready_i = 1'b0;
    drive(1, 1, 0, 64'd40, 3'd0, 10'd8); tick();
    for (int i = 1; i < 4; i++) begin
      drive(1, 0, 0, 64'(40 + i), 3'd0, 10'd8);
      tick();
    end
    chk("stored_before_rst", 64'(q.size()), 64'd4);
    drive(0, 0, 0, 0, 0, 0);
    srst = 1'b1;
    tick();
    chk("valid_after_rst", 64'(valid_o), 64'd0);
    srst = 1'b0;
    drive(1, 0, 0, 64'd44, 3'd0, 10'd8);
    tick();
    chk("post_rst_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("post_rst_not_output", 64'(valid_o), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    ready_i = 1'b1;
    tick();

    // Randomised traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      srst    = ($urandom_range(0, 249) == 0);
      ready_i = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            {$urandom, $urandom}, 3'($urandom), 10'($urandom));
      tick();
    end
    srst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
